// File: rtl/ntt_pkg.sv
// Shared types and modular add/sub helpers for the NTT butterfly datapath.
// Helpers work on zero-extended MAX_W operands, so any coefficient width up to MAX_W can use them.
package ntt_pkg;

    localparam int DATA_W = 32;
    localparam int MAX_W  = 64;

    typedef logic [DATA_W-1:0] coef_t;
    typedef logic [MAX_W-1:0]  wide_t;

    typedef enum logic {
        BF_CT = 1'b0,
        BF_GS = 1'b1
    } bfly_mode_e;

    // Both operands must already be < m.
    function automatic wide_t mod_add(input wide_t a, input wide_t b, input wide_t m);
        logic [MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[MAX_W-1:0];
    endfunction

    function automatic wide_t mod_sub(input wide_t a, input wide_t b, input wide_t m);
        logic signed [MAX_W:0] d;
        d = signed'({1'b0, a}) - signed'({1'b0, b});
        if (d < 0) d = d + signed'({1'b0, m});
        return d[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/ntt_bfly_pe_if.sv
// Coefficient stream bundle for the butterfly PE: input beat, output beat, modulus and busy.
// master = the side feeding/draining the PE, slave = the PE itself.
interface ntt_bfly_pe_if #(
    parameter int DATA_W = ntt_pkg::DATA_W
);
    logic [DATA_W-1:0] q;
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [DATA_W-1:0] in_w;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              busy;

    modport master (
        output q, in_valid, in_mode, in_a, in_b, in_w, out_ready,
        input  in_ready, out_valid, out_a, out_b, busy
    );

    modport slave (
        input  q, in_valid, in_mode, in_a, in_b, in_w, out_ready,
        output in_ready, out_valid, out_a, out_b, busy
    );
endinterface

// File: rtl/mod_mult_pipe.sv
// Pipelined modular multiplier c = a*b mod q using MSB-first interleaved (Horner) reduction,
// with the multiplier bits split evenly across MULT_LAT enabled stages.
module mod_mult_pipe
    import ntt_pkg::*;
#(
    parameter int DATA_W   = ntt_pkg::DATA_W,
    parameter int MULT_LAT = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] c
);

    localparam int BPS = (DATA_W + MULT_LAT - 1) / MULT_LAT;
    localparam int BW  = BPS * MULT_LAT;

    logic [BW-1:0]     b_ext;
    logic [DATA_W-1:0] r_q [MULT_LAT];
    logic [DATA_W-1:0] a_q [MULT_LAT];
    logic [BW-1:0]     b_q [MULT_LAT];

    // Each step doubles the accumulator and adds md when the bit is set; r stays < m throughout.
    function automatic logic [DATA_W-1:0] mac_chunk(input logic [DATA_W-1:0] r,
                                                    input logic [DATA_W-1:0] md,
                                                    input logic [BPS-1:0]    bits,
                                                    input logic [DATA_W-1:0] m);
        logic [DATA_W-1:0] acc;
        acc = r;
        for (int k = BPS - 1; k >= 0; k--) begin
            acc = DATA_W'(mod_add(MAX_W'(acc), MAX_W'(acc), MAX_W'(m)));
            if (bits[k]) acc = DATA_W'(mod_add(MAX_W'(acc), MAX_W'(md), MAX_W'(m)));
        end
        return acc;
    endfunction

    assign b_ext = BW'(b);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MULT_LAT; i++) r_q[i] <= '0;
        end else if (en) begin
            r_q[0] <= mac_chunk('0, a, b_ext[BW-1 -: BPS], q);
            for (int i = 1; i < MULT_LAT; i++)
                r_q[i] <= mac_chunk(r_q[i-1], a_q[i-1], b_q[i-1][BW-1 -: BPS], q);
        end
    end

    // Operand copies travel with the partial result; b is shifted so the next chunk sits on top.
    always_ff @(posedge clk) begin
        if (en) begin
            a_q[0] <= a;
            b_q[0] <= b_ext << BPS;
            for (int i = 1; i < MULT_LAT; i++) begin
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1] << BPS;
            end
        end
    end

    assign c = r_q[MULT_LAT-1];

endmodule

// File: rtl/ntt_bfly_pe.sv
// Fully pipelined radix-2 NTT/INTT butterfly: Cooley-Tukey or Gentleman-Sande selected per beat,
// fixed latency MULT_LAT+2, whole-pipeline stall when the output register is full and not taken.
module ntt_bfly_pe
    import ntt_pkg::*;
#(
    parameter int DATA_W   = ntt_pkg::DATA_W,
    parameter int MULT_LAT = 6
) (
    input  logic           clk,
    input  logic           reset,
    ntt_bfly_pe_if.slave   bus
);

    localparam int LAST = MULT_LAT - 1;

    logic              adv;

    logic              vld_p0;
    bfly_mode_e        mode_p0;
    logic [DATA_W-1:0] x_p0;
    logic [DATA_W-1:0] y_p0;
    logic [DATA_W-1:0] w_p0;

    logic [MULT_LAT-1:0] vld_p1;
    bfly_mode_e          mode_p1 [MULT_LAT];
    logic [DATA_W-1:0]   y_p1    [MULT_LAT];
    logic [DATA_W-1:0]   prod_p1;
    logic [DATA_W-1:0]   sum_p1;
    logic [DATA_W-1:0]   dif_p1;

    logic              vld_p2;
    logic [DATA_W-1:0] a_p2;
    logic [DATA_W-1:0] b_p2;

    assign adv          = bus.out_ready | ~vld_p2;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld_p2;
    assign bus.out_a    = a_p2;
    assign bus.out_b    = b_p2;
    assign bus.busy     = vld_p0 | (|vld_p1) | vld_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= '0;
        end else if (adv) begin
            vld_p0    <= bus.in_valid;
            vld_p1[0] <= vld_p0;
            for (int i = 1; i < MULT_LAT; i++) vld_p1[i] <= vld_p1[i-1];
        end
    end

    // ---- p0: GS pre-add/sub; CT forwards a (partner) and b (multiplicand) untouched
    always_ff @(posedge clk) begin
        if (adv) begin
            mode_p0 <= bfly_mode_e'(bus.in_mode);
            w_p0    <= bus.in_w;
            if (bfly_mode_e'(bus.in_mode) == BF_GS) begin
                x_p0 <= DATA_W'(mod_sub(MAX_W'(bus.in_a), MAX_W'(bus.in_b), MAX_W'(bus.q)));
                y_p0 <= DATA_W'(mod_add(MAX_W'(bus.in_a), MAX_W'(bus.in_b), MAX_W'(bus.q)));
            end else begin
                x_p0 <= bus.in_b;
                y_p0 <= bus.in_a;
            end
        end
    end

    // ---- p1: multiplier stages, partner and mode delayed to line up with the product
    mod_mult_pipe #(
        .DATA_W   (DATA_W),
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .a     (w_p0),
        .b     (x_p0),
        .q     (bus.q),
        .c     (prod_p1)
    );

    always_ff @(posedge clk) begin
        if (adv) begin
            mode_p1[0] <= mode_p0;
            y_p1[0]    <= y_p0;
            for (int i = 1; i < MULT_LAT; i++) begin
                mode_p1[i] <= mode_p1[i-1];
                y_p1[i]    <= y_p1[i-1];
            end
        end
    end

    always_comb begin
        sum_p1 = DATA_W'(mod_add(MAX_W'(y_p1[LAST]), MAX_W'(prod_p1), MAX_W'(bus.q)));
        dif_p1 = DATA_W'(mod_sub(MAX_W'(y_p1[LAST]), MAX_W'(prod_p1), MAX_W'(bus.q)));
    end

    // ---- p2: CT post-add/sub, GS pass-through; this is the output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2 <= 1'b0;
            a_p2   <= '0;
            b_p2   <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1[LAST];
            if (mode_p1[LAST] == BF_CT) begin
                a_p2 <= sum_p1;
                b_p2 <= dif_p1;
            end else begin
                a_p2 <= y_p1[LAST];
                b_p2 <= prod_p1;
            end
        end
    end

endmodule

// File: tb/tb_ntt_bfly_pe.sv
// Directed bench for ntt_bfly_pe: single beats in both modes, full-width carry, mixed stream
// with and without a downstream stall, and asynchronous reset with beats in flight.
module tb_ntt_bfly_pe;
    import ntt_pkg::*;

    localparam int LAT = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ntt_bfly_pe_if #(.DATA_W(32)) bus ();

    ntt_bfly_pe #(.DATA_W(32), .MULT_LAT(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Stream vectors, q = 17; even index CT, odd index GS; expectations worked by hand.
    int sa  [10] = '{1, 1, 10, 10, 0, 0, 12, 12, 16, 3};
    int sb  [10] = '{2, 2, 5, 5, 9, 9, 11, 11, 1, 8};
    int sw  [10] = '{3, 3, 7, 7, 2, 2, 13, 13, 1, 5};
    int sea [10] = '{7, 3, 11, 15, 1, 9, 2, 6, 0, 11};
    int seb [10] = '{12, 14, 9, 1, 16, 16, 5, 13, 15, 9};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_beat(input int i);
        bus.in_valid = 1'b1;
        bus.in_mode  = i[0];
        bus.in_a     = sa[i];
        bus.in_b     = sb[i];
        bus.in_w     = sw[i];
    endtask

    task automatic run_one(input string tag, input logic mode, input coef_t a, input coef_t b,
                           input coef_t w, input coef_t ea, input coef_t eb);
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = mode;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_w      = w;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_a"}, bus.out_a, ea);
        chk({tag, "_b"}, bus.out_b, eb);
        @(posedge clk);
        #1 chk({tag, "_drained"}, bus.out_valid, 1'b0);
    endtask

    task automatic run_stream(input string tag, input int stall_at, input int span_exp);
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        int   first = -1;
        int   lastc = -1;
        bit   held = 0;
        coef_t ha = '0;
        coef_t hb = '0;
        while (got < 10 && cyc < 100) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                chk({tag, "_in_ready_stall"}, bus.in_ready, 1'b0);
                if (held) begin
                    chk({tag, "_hold_a"}, bus.out_a, ha);
                    chk({tag, "_hold_b"}, bus.out_b, hb);
                end
                ha = bus.out_a;
                hb = bus.out_b;
                held = 1;
            end else begin
                held = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("%s_a%0d", tag, got), bus.out_a, sea[got]);
                chk($sformatf("%s_b%0d", tag, got), bus.out_b, seb[got]);
                if (first < 0) first = cyc;
                lastc = cyc;
                if (got == 9) chk({tag, "_busy_last"}, bus.busy, 1'b1);
                got++;
            end
            if (sent < 10) begin
                drive_beat(sent);
                if (bus.in_ready) sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            cyc++;
        end
        chk({tag, "_count"}, got, 10);
        chk({tag, "_first"}, first, LAT);
        chk({tag, "_span"}, lastc - first + 1, span_exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk({tag, "_busy_done"}, bus.busy, 1'b0);
        chk({tag, "_no_dup"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.q         = 17;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b1;

        #3;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_out_a", bus.out_a, 0);
        chk("rst_out_b", bus.out_b, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rel_in_ready", bus.in_ready, 1'b1);

        run_one("ct_basic", 1'b0, 5, 3, 4, 0, 10);
        run_one("gs_basic", 1'b1, 5, 3, 4, 8, 8);
        run_one("gs_borrow", 1'b1, 0, 16, 1, 16, 1);
        run_one("ct_max17", 1'b0, 16, 16, 16, 0, 15);

        @(negedge clk);
        bus.q = 32'hFFFF_FFFB;
        run_one("ct_full", 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 0, 32'hFFFF_FFF9);

        @(negedge clk);
        bus.q = 17;
        run_stream("strm", 1000, 10);
        run_stream("stall", 9, 13);

        // Four beats parked behind a stalled output, then reset between clock edges.
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_beat(i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        chk("pre_rst_a", bus.out_a, sea[0]);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 1'b0);
        chk("async_busy", bus.busy, 1'b0);
        chk("async_out_a", bus.out_a, 0);
        chk("async_out_b", bus.out_b, 0);
        @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        reset = 1'b1;
        #1 chk("rel2_in_ready", bus.in_ready, 1'b1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) cnt++;
        end
        chk("post_rst_quiet", cnt, 0);
        run_one("post_rst", 1'b1, 10, 5, 7, 15, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ntt_bfly_pe.md
Name: ntt_bfly_pe

Overview:
- Parametrised, fully pipelined radix-2 NTT/INTT butterfly processing element. Successor to the serial single-mode PE.
- Accepts one coefficient pair plus one twiddle per beat and selects the butterfly form per beat:
  - Cooley-Tukey (forward NTT)
  - Gentleman-Sande (inverse NTT)
- Sits between the coefficient memory read port and the write-back path. Uses a valid/ready stream on both sides with full-pipeline backpressure.

Parameters:
- DATA_W, 32, coefficient/modulus width in bits
- MULT_LAT, 6, pipeline depth of the modular multiplier sub-module (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- q  in  DATA_W  modulus; odd, 3 <= q < 2^DATA_W; held stable while busy=1
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_mode  in  1  0 = CT (forward), 1 = GS (inverse)
- in_a  in  DATA_W  even coefficient, < q
- in_b  in  DATA_W  odd coefficient, < q
- in_w  in  DATA_W  twiddle, < q
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_a  out  DATA_W  result even
- out_b  out  DATA_W  result odd
- busy  out  1  any valid beat inside the pipeline

Behaviour:
- Arithmetic is mod q on all results; every output is < q.
  - CT: out_a = (a + w*b) mod q; out_b = (a - w*b) mod q.
  - GS: out_a = (a + b) mod q; out_b = ((a - b)*w) mod q.
- Modular add: DATA_W+1-bit sum, subtract q if sum >= q.
- Modular sub: DATA_W+1-bit difference, add q if the result is negative.
- Pipeline stages, each carrying valid and mode:
  - S0: GS computes the add/sub and registers it; CT registers a and b unchanged.
  - S1..S(MULT_LAT): the multiplier takes (CT: b, GS: a-b) times w. The partner operand (CT: a, GS: a+b) is delayed MULT_LAT cycles alongside it.
  - S_last: CT performs the add/sub on (a, w*b); GS passes the values through. This stage is the output register.
- Latency is fixed at LAT = MULT_LAT + 2 cycles from accept to out_valid, with no stalls, for both modes. Modes may be mixed beat to beat. Order is preserved.
- Stall: adv = out_ready | ~out_valid; in_ready = adv.
  - When adv=0, every stage register holds, including multiplier internals.
  - Bubbles are not compressed.
- Throughput is one beat per cycle when out_ready=1.
- When out_valid=1 and out_ready=0, out_a and out_b hold stable until the beat is taken.
- busy = OR of all stage valid bits.
- Reset (reset=0, asynchronous):
  - All valid bits clear immediately; out_valid=0, busy=0, out_a=out_b=0.
  - in_ready=1 on release.
  - In-flight beats are discarded; nothing emerges after release.
- Data registers need no reset except the output register.
- q changes while busy=1 give undefined results; no checking is required.
- Inputs with value >= q: results are undefined.

Decomposition:
- Package ntt_pkg:
  - DATA_W default constant
  - typedef coef_t = logic [DATA_W-1:0]
  - enum bfly_mode_e {BF_CT=0, BF_GS=1}
  - functions mod_add and mod_sub (width-generic, DATA_W+1 internal)
- Sub-module mod_mult_pipe:
  - Ports: clk, reset, en, a, b, q, c.
  - Behaviour: c = (a*b) mod q after MULT_LAT enabled cycles; Barrett or equivalent reduction.
  - en is tied to adv.

Test Plan:
- q=17, CT, a=5, b=3, w=4, out_ready=1 -> out_a=0, out_b=10, out_valid exactly MULT_LAT+2 cycles after accept.
- q=17, GS, a=5, b=3, w=4 -> out_a=8, out_b=8. Repeat with a=0, b=16, w=1 -> out_a=16, out_b=1 (borrow wrap).
- q=17, CT, a=b=w=16 -> out_a=0, out_b=15. DATA_W=32, q=4294967291, CT, a=b=w=q-1 -> out_a=0, out_b=q-2 (full-width carry path).
- Stream of 10 back-to-back beats alternating CT/GS with out_ready=1 -> 10 consecutive out_valid cycles, correct per-beat mode results, order preserved.
- Same stream with out_ready=0 for 3 cycles mid-stream -> out_a/out_b stable while stalled, in_ready=0 during stall, no lost or duplicated beats, busy falls 1 cycle after the last output is taken.
- Assert reset with 4 beats in flight -> out_valid and busy go to 0 without a clock edge. After release, no output appears until a new beat is accepted; the new beat's result is correct.
